// File: rtl/pipeline_hazard_controller.sv
// Hazard sequencer for the 5-stage pipeline: load-use/flag-use bubbles,
// IF/ID flush on taken branch, whole-pipe freeze on busy data memory.
module pipeline_hazard_controller #(
  parameter int LOAD_USE_STALLS = 1,
  parameter int FLAG_STALLS     = 1,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_ID,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             rs1_used_ID,
  input  logic             rs2_used_ID,
  input  logic             condbr_ID,
  input  logic             brtaken_ID,
  input  logic             memread_EX,
  input  logic [4:0]       rd_EX,
  input  logic             setflag_EX,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {RUN, STALL, FREEZE} state_t;

  localparam logic [1:0]       LU_LOAD = 2'(LOAD_USE_STALLS - 1);
  localparam logic [1:0]       FU_LOAD = 2'(FLAG_STALLS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state;
  state_t     ret_state;
  logic [1:0] scnt;
  logic       lu;
  logic       fu;

  // XZR is hardwired to zero, so a load into X31 never creates a dependency
  assign lu = valid_ID & memread_EX & (rd_EX != 5'd31) &
              ((rs1_used_ID & (rs1_ID == rd_EX)) | (rs2_used_ID & (rs2_ID == rd_EX)));
  assign fu = valid_ID & condbr_ID & setflag_EX;

  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    idex_write  = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    if (reset) begin
      idex_bubble = 1'b1;
      ifid_flush  = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (!mem_busy) begin
            if (lu || fu) begin
              idex_write  = 1'b1;
              idex_bubble = 1'b1;
            end else begin
              pc_write   = 1'b1;
              ifid_write = 1'b1;
              idex_write = 1'b1;
              ifid_flush = valid_ID & brtaken_ID;
            end
          end
        end
        STALL: begin
          if (!mem_busy) begin
            idex_write  = 1'b1;
            idex_bubble = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // The remaining-bubble count is frozen along with the pipe so a stall
  // interrupted by memory resumes exactly where it left off
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      ret_state <= RUN;
      scnt      <= 2'd0;
    end else begin
      unique case (state)
        RUN: begin
          if (mem_busy) begin
            ret_state <= RUN;
            state     <= FREEZE;
          end else if (lu) begin
            scnt  <= LU_LOAD;
            state <= (LU_LOAD != 2'd0) ? STALL : RUN;
          end else if (fu) begin
            scnt  <= FU_LOAD;
            state <= (FU_LOAD != 2'd0) ? STALL : RUN;
          end
        end
        STALL: begin
          if (mem_busy) begin
            ret_state <= STALL;
            state     <= FREEZE;
          end else begin
            scnt <= scnt - 2'd1;
            if (scnt == 2'd1) state <= RUN;
          end
        end
        FREEZE: begin
          if (!mem_busy) state <= ret_state;
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (idex_bubble && stall_count != CNT_MAX) stall_count <= stall_count + CNT_ONE;
      if (ifid_flush && flush_count != CNT_MAX) flush_count <= flush_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: two parameterisations driven in lockstep,
// checked against a bubble-budget model plus directed vectors.
module tb_pipeline_hazard_controller;

  typedef struct {
    logic       rst;
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       cb;
    logic       bt;
    logic       mr;
    logic [4:0] rd;
    logic       sf;
    logic       busy;
  } vec_t;

  typedef struct {
    vec_t       v;
    logic [4:0] exp_out;
    int         exp_sc;
    int         exp_fc;
  } rec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid_id = 1'b0, rs1_used = 1'b0, rs2_used = 1'b0;
  logic       condbr = 1'b0, brtaken = 1'b0, memread = 1'b0, setflag = 1'b0, mem_busy = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;

  logic        a_pc, a_ifid, a_idex, a_bub, a_flush;
  logic        b_pc, b_ifid, b_idex, b_bub, b_flush;
  logic [15:0] a_sc, a_fc;
  logic [3:0]  b_sc, b_fc;

  int errors = 0;
  int checks = 0;

  // model state per instance: bubbles still owed, frozen flag, counters
  int p_lus [2] = '{1, 3};
  int p_fs  [2] = '{1, 2};
  int p_max [2] = '{65535, 15};
  int m_rem [2];
  bit m_frz [2];
  int m_sc  [2];
  int m_fc  [2];

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.LOAD_USE_STALLS(1), .FLAG_STALLS(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .valid_ID(valid_id), .rs1_ID(rs1), .rs2_ID(rs2),
    .rs1_used_ID(rs1_used), .rs2_used_ID(rs2_used), .condbr_ID(condbr), .brtaken_ID(brtaken),
    .memread_EX(memread), .rd_EX(rd), .setflag_EX(setflag), .mem_busy(mem_busy),
    .pc_write(a_pc), .ifid_write(a_ifid), .idex_write(a_idex), .idex_bubble(a_bub),
    .ifid_flush(a_flush), .stall_count(a_sc), .flush_count(a_fc));

  pipeline_hazard_controller #(.LOAD_USE_STALLS(3), .FLAG_STALLS(2), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .valid_ID(valid_id), .rs1_ID(rs1), .rs2_ID(rs2),
    .rs1_used_ID(rs1_used), .rs2_used_ID(rs2_used), .condbr_ID(condbr), .brtaken_ID(brtaken),
    .memread_EX(memread), .rd_EX(rd), .setflag_EX(setflag), .mem_busy(mem_busy),
    .pc_write(b_pc), .ifid_write(b_ifid), .idex_write(b_idex), .idex_bubble(b_bub),
    .ifid_flush(b_flush), .stall_count(b_sc), .flush_count(b_fc));

  function automatic vec_t mk(bit r, bit v, int s1, int s2, bit u1, bit u2, bit cb, bit bt,
                              bit mr, int d, bit sf, bit busy);
    vec_t x;
    x.rst = r; x.valid = v; x.rs1 = 5'(s1); x.rs2 = 5'(s2); x.u1 = u1; x.u2 = u2;
    x.cb = cb; x.bt = bt; x.mr = mr; x.rd = 5'(d); x.sf = sf; x.busy = busy;
    return x;
  endfunction

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Expected strobes {pc, ifid, idex, bubble, flush} from the hazard rules,
  // tracked as a bubble budget rather than named states
  task automatic model_cycle(input int k, input vec_t v, output logic [4:0] exp);
    bit lu, fu;
    lu = v.valid && v.mr && v.rd != 31 &&
         ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
    fu = v.valid && v.cb && v.sf;
    if (v.rst) begin
      exp = 5'b00011;
      m_rem[k] = 0; m_frz[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
    end else if (m_frz[k]) begin
      exp = 5'b00000;
      if (!v.busy) m_frz[k] = 0;
    end else if (v.busy) begin
      exp = 5'b00000;
      m_frz[k] = 1;
    end else if (m_rem[k] > 0) begin
      exp = 5'b00110;
      m_rem[k]--;
    end else if (lu) begin
      exp = 5'b00110;
      m_rem[k] = p_lus[k] - 1;
    end else if (fu) begin
      exp = 5'b00110;
      m_rem[k] = p_fs[k] - 1;
    end else begin
      exp = (v.valid && v.bt) ? 5'b11101 : 5'b11100;
    end
  endtask

  task automatic apply_stimulus(input vec_t v, input string tag,
                                output logic [4:0] got_a, output logic [4:0] got_b);
    logic [4:0] exp_a, exp_b;
    @(negedge clk);
    reset = v.rst; valid_id = v.valid; rs1 = v.rs1; rs2 = v.rs2;
    rs1_used = v.u1; rs2_used = v.u2; condbr = v.cb; brtaken = v.bt;
    memread = v.mr; rd = v.rd; setflag = v.sf; mem_busy = v.busy;
    #1;
    got_a = {a_pc, a_ifid, a_idex, a_bub, a_flush};
    got_b = {b_pc, b_ifid, b_idex, b_bub, b_flush};
    model_cycle(0, v, exp_a);
    model_cycle(1, v, exp_b);
    check_output({tag, " a.strobes"}, int'(got_a), int'(exp_a));
    check_output({tag, " a.stall_count"}, int'(a_sc), m_sc[0]);
    check_output({tag, " a.flush_count"}, int'(a_fc), m_fc[0]);
    check_output({tag, " b.strobes"}, int'(got_b), int'(exp_b));
    check_output({tag, " b.stall_count"}, int'(b_sc), m_sc[1]);
    check_output({tag, " b.flush_count"}, int'(b_fc), m_fc[1]);
    if (!v.rst) begin
      if (exp_a[1] && m_sc[0] < p_max[0]) m_sc[0]++;
      if (exp_a[0] && m_fc[0] < p_max[0]) m_fc[0]++;
      if (exp_b[1] && m_sc[1] < p_max[1]) m_sc[1]++;
      if (exp_b[0] && m_fc[1] < p_max[1]) m_fc[1]++;
    end
  endtask

  initial begin
    rec_t       tbl[12];
    vec_t       idle, luv, v;
    logic [4:0] ga, gb;
    int         bubbles, frozen;

    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    luv  = mk(0, 1, 1, 0, 1, 0, 0, 0, 1, 1, 0, 0);

    tbl[0]  = '{mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),    5'b00011, 0, 0};
    tbl[1]  = '{idle,                                      5'b11100, 0, 0};
    tbl[2]  = '{luv,                                       5'b00110, 0, 0};
    tbl[3]  = '{mk(0, 1, 2, 0, 1, 0, 0, 0, 1, 1, 0, 0),    5'b11100, 1, 0};
    tbl[4]  = '{mk(0, 1, 31, 0, 1, 0, 0, 0, 1, 31, 0, 0),  5'b11100, 1, 0};
    tbl[5]  = '{mk(0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0),    5'b00110, 1, 0};
    tbl[6]  = '{mk(0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0),    5'b11101, 2, 0};
    tbl[7]  = '{mk(0, 1, 0, 5, 0, 1, 0, 1, 1, 5, 0, 0),    5'b00110, 2, 1};
    tbl[8]  = '{mk(0, 0, 1, 0, 1, 0, 0, 0, 1, 1, 0, 0),    5'b11100, 3, 1};
    tbl[9]  = '{mk(0, 1, 4, 0, 0, 1, 0, 0, 1, 4, 0, 0),    5'b11100, 3, 1};
    tbl[10] = '{mk(0, 1, 3, 0, 1, 0, 1, 0, 1, 3, 1, 0),    5'b00110, 3, 1};
    tbl[11] = '{mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0),    5'b11100, 4, 1};

    for (int i = 0; i < 12; i++) begin
      apply_stimulus(tbl[i].v, $sformatf("tbl%0d", i), ga, gb);
      check_output($sformatf("tbl%0d strobes", i), int'(ga), int'(tbl[i].exp_out));
      check_output($sformatf("tbl%0d stall_count", i), int'(a_sc), tbl[i].exp_sc);
      check_output($sformatf("tbl%0d flush_count", i), int'(a_fc), tbl[i].exp_fc);
    end

    // three-bubble load-use stall interrupted by memory in its second cycle
    apply_stimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "mf.rst", ga, gb);
    bubbles = 0; frozen = 0;
    apply_stimulus(luv, "mf.c0", ga, gb);
    bubbles += int'(gb[1]);
    for (int i = 1; i < 6; i++) begin
      v = idle;
      v.busy = (i == 2 || i == 3);
      apply_stimulus(v, $sformatf("mf.c%0d", i), ga, gb);
      bubbles += int'(gb[1]);
      frozen  += int'(gb == 5'b00000);
    end
    apply_stimulus(idle, "mf.end", ga, gb);
    check_output("mf bubbles", bubbles, 3);
    check_output("mf frozen", frozen, 3);
    check_output("mf stall_count", int'(b_sc), 3);
    check_output("mf resumes", int'(gb), int'(5'b11100));

    // saturation of the 4-bit counter
    apply_stimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "sat.rst", ga, gb);
    for (int i = 0; i < 20; i++) apply_stimulus(luv, $sformatf("sat%0d", i), ga, gb);
    apply_stimulus(idle, "sat.end", ga, gb);
    check_output("sat b.stall_count", int'(b_sc), 15);
    check_output("sat a.stall_count", int'(a_sc), 20);

    // reset landing in the middle of a stall
    apply_stimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rs.rst0", ga, gb);
    apply_stimulus(luv, "rs.lu", ga, gb);
    apply_stimulus(idle, "rs.stall", ga, gb);
    check_output("rs mid-stall bubble", int'(gb), int'(5'b00110));
    apply_stimulus(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "rs.rst1", ga, gb);
    check_output("rs forced", int'(gb), int'(5'b00011));
    apply_stimulus(idle, "rs.release", ga, gb);
    check_output("rs pc_write", int'(b_pc), 1);
    check_output("rs b.stall_count", int'(b_sc), 0);
    check_output("rs a.stall_count", int'(a_sc), 0);

    // randomized traffic over a small register set to provoke hazards often
    for (int i = 0; i < 400; i++) begin
      int r;
      v.rst   = ($urandom_range(0, 49) == 0);
      v.valid = ($urandom_range(0, 9) != 0);
      r = $urandom_range(0, 4); v.rs1 = (r == 4) ? 5'd31 : 5'(r);
      r = $urandom_range(0, 4); v.rs2 = (r == 4) ? 5'd31 : 5'(r);
      r = $urandom_range(0, 4); v.rd  = (r == 4) ? 5'd31 : 5'(r);
      v.u1   = 1'($urandom_range(0, 1));
      v.u2   = 1'($urandom_range(0, 1));
      v.cb   = 1'($urandom_range(0, 1));
      v.bt   = 1'($urandom_range(0, 1));
      v.mr   = 1'($urandom_range(0, 1));
      v.sf   = 1'($urandom_range(0, 1));
      v.busy = ($urandom_range(0, 6) == 0);
      apply_stimulus(v, $sformatf("rnd%0d", i), ga, gb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
